// File: rtl/summation_rate_decoder_if.sv
// summation_rate_decoder_if
// Groups the sample/control inputs and result outputs of the carry-pulse
// decoder into one bundle.
//   en, clr, cop, con : sample enable, synchronous clear, carry pulses
//   net_cnt           : signed K+2, net carry count of the last window
//   addend_est        : signed 11, reconstructed average addend
//   est_sat, valid    : clamp flag, one-cycle result strobe
// master: producer of pulses / consumer of results; slave: the decoder.
interface summation_rate_decoder_if #(
    parameter int unsigned K = 4
);
    logic                en;
    logic                clr;
    logic                cop;
    logic                con;
    logic signed [K+1:0] net_cnt;
    logic signed [10:0]  addend_est;
    logic                est_sat;
    logic                valid;

    modport master (
        output en, clr, cop, con,
        input  net_cnt, addend_est, est_sat, valid
    );

    modport slave (
        input  en, clr, cop, con,
        output net_cnt, addend_est, est_sat, valid
    );
endinterface

// File: rtl/summation_rate_decoder.sv
// summation_rate_decoder
// Counts positive/negative carry pulses of a modulo-M accumulator over a
// window of 2^K sampled cycles and reconstructs the average signed addend
// as floor(net * M / 2^K), clamped to the 11-bit signed range.
// Ports:
//   clk  : clock, rising edge
//   arst : asynchronous active-high reset
//   bus  : summation_rate_decoder_if slave (en, clr, cop, con in;
//          net_cnt, addend_est, est_sat, valid out)
module summation_rate_decoder #(
    parameter int unsigned M = 1000,
    parameter int unsigned K = 4
) (
    input logic                    clk,
    input logic                    arst,
    summation_rate_decoder_if.slave bus
);

    // K=0 still needs a 1-bit counter vector; it simply stays at zero.
    localparam int unsigned WCW = (K == 0) ? 1 : K;
    // Product width: net (K+2) times M as a signed operand (clog2(M)+1).
    localparam int unsigned PW  = K + 2 + $clog2(M) + 1;
    localparam logic [WCW-1:0] WLAST = WCW'((1 << K) - 1);

    logic signed [K+1:0] w_d;
    logic                w_final;
    logic signed [PW-1:0] w_net_ext;
    logic signed [PW-1:0] w_m;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_q;
    logic signed [31:0]   w_q32;
    logic signed [10:0]   w_est;
    logic                 w_sat;

    logic signed [K+1:0] r_acc_q, r_acc_d;
    logic signed [K+1:0] r_net_q, r_net_d;
    logic [WCW-1:0]      r_wcnt_q, r_wcnt_d;
    logic                r_pend_q, r_pend_d;
    logic signed [10:0]  r_est_q, r_est_d;
    logic                r_sat_q, r_sat_d;
    logic                r_valid_q, r_valid_d;

    // Per-sample contribution: coincident pulses cancel.
    always_comb begin
        w_d = '0;
        if (bus.cop && !bus.con) begin
            w_d = {{(K+1){1'b0}}, 1'b1};
        end else if (bus.con && !bus.cop) begin
            w_d = '1;
        end
    end

    assign w_final = (K == 0) ? 1'b1 : (r_wcnt_q == WLAST);

    // Reconstruction runs off the registered net count in the pending cycle.
    assign w_net_ext = {{(PW-K-2){r_net_q[K+1]}}, r_net_q};
    assign w_m       = PW'(M);
    assign w_prod    = w_net_ext * w_m;
    assign w_q       = w_prod >>> K;
    assign w_q32     = {{(32-PW){w_q[PW-1]}}, w_q};

    always_comb begin
        w_est = w_q32[10:0];
        w_sat = 1'b0;
        if (w_q32 > 32'sd1023) begin
            w_est = 11'sd1023;
            w_sat = 1'b1;
        end else if (w_q32 < -32'sd1024) begin
            w_est = -11'sd1024;
            w_sat = 1'b1;
        end
    end

    always_comb begin
        r_acc_d   = r_acc_q;
        r_net_d   = r_net_q;
        r_wcnt_d  = r_wcnt_q;
        r_pend_d  = r_pend_q;
        r_est_d   = r_est_q;
        r_sat_d   = r_sat_q;
        r_valid_d = 1'b0;

        if (bus.clr) begin
            r_acc_d  = '0;
            r_wcnt_d = '0;
            r_pend_d = 1'b0;
        end else begin
            if (r_pend_q) begin
                r_est_d   = w_est;
                r_sat_d   = w_sat;
                r_valid_d = 1'b1;
                r_pend_d  = 1'b0;
            end
            // Evaluated after the pending block so that with K=0 a new
            // final sample re-arms pending in the same cycle.
            if (bus.en) begin
                if (w_final) begin
                    r_net_d  = r_acc_q + w_d;
                    r_acc_d  = '0;
                    r_wcnt_d = '0;
                    r_pend_d = 1'b1;
                end else begin
                    r_acc_d  = r_acc_q + w_d;
                    r_wcnt_d = r_wcnt_q + WCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_acc_q   <= '0;
            r_net_q   <= '0;
            r_wcnt_q  <= '0;
            r_pend_q  <= 1'b0;
            r_est_q   <= '0;
            r_sat_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_acc_q   <= r_acc_d;
            r_net_q   <= r_net_d;
            r_wcnt_q  <= r_wcnt_d;
            r_pend_q  <= r_pend_d;
            r_est_q   <= r_est_d;
            r_sat_q   <= r_sat_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign bus.net_cnt    = r_net_q;
    assign bus.addend_est = r_est_q;
    assign bus.est_sat    = r_sat_q;
    assign bus.valid      = r_valid_q;

endmodule
